// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage drives the address; memory returns the word and a ready flag.
interface if_fetch_unit_if;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output addr,
    input  rdata,
    input  ready
  );

  modport slave (
    input  addr,
    output rdata,
    output ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC register, imem ready/wait handshake, redirects and flushes.
// Optional PERF_CNT_EN adds saturating fetch/stall cycle counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  input  logic        illop_i,
  input  logic        irq_i,
  if_fetch_unit_if.master imem,
  output logic [31:0] pc_o,
  output logic [31:0] if_pc_4_o,
  output logic [31:0] if_instruct_o,
  output logic        if_valid_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;

  logic [31:0] pc_inc;
  logic        irq_eff;
  logic        sel_ill, sel_irq;
  logic        sel_br, sel_jmp;
  logic        redir;
  logic        hard_flush;
  logic [31:0] redir_pc;
  logic        valid;
  logic [31:0] seq_pc;

  // Bit 31 is the supervisor flag; the increment never crosses halves.
  assign pc_inc  = {pc_q[31], pc_q[30:0] + 31'd4};
  assign irq_eff = irq_i & ~pc_q[31];

  assign sel_ill = illop_i;
  assign sel_irq = irq_eff & ~illop_i;
  assign sel_br  = br_taken_i & ~illop_i & ~irq_eff;
  assign sel_jmp = jmp_i & ~illop_i & ~irq_eff
                 & ~br_taken_i;

  assign redir      = sel_ill | sel_irq | sel_br | sel_jmp;
  assign hard_flush = sel_ill | sel_irq | sel_br;

  always_comb begin
    redir_pc = pc_inc;
    unique case (1'b1)
      sel_ill: redir_pc = ILLOP_PC;
      sel_irq: redir_pc = XADR_PC;
      sel_br:  redir_pc = br_target_i;
      sel_jmp: redir_pc = jmp_target_i;
      default: redir_pc = pc_inc;
    endcase
  end

  assign seq_pc = redir   ? redir_pc :
                  stall_i ? pc_q     : pc_inc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    valid        = 1'b0;
    unique case (state_q)
      RUN: begin
        if (imem.ready) begin
          valid = 1'b1;
          pc_d  = seq_pc;
        end else begin
          state_d = WAIT;
          if (redir) begin
            pend_pc_d    = redir_pc;
            pend_valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem.ready) begin
          state_d      = RUN;
          pend_valid_d = 1'b0;
          if (pend_valid_q) begin
            pc_d = redir ? redir_pc : pend_pc_q;
          end else begin
            valid = 1'b1;
            pc_d  = seq_pc;
          end
        end else if (redir) begin
          pend_pc_d    = redir_pc;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Outputs read as a quiet nop while reset is held.
  assign pc_o          = pc_q;
  assign imem.addr     = pc_q;
  assign if_valid_o    = valid & reset;
  assign if_instruct_o = if_valid_o ? imem.rdata : '0;
  assign if_pc_4_o     = if_valid_o ? pc_inc : '0;
  assign flush_if_id_o = redir & reset;
  assign flush_id_ex_o = hard_flush & reset;

`ifdef PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        fetch_ev, stall_ev;

  assign fetch_ev = if_valid_o & ~stall_i;
  assign stall_ev = stall_i | (state_q == WAIT);

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (fetch_ev && perf_fetch_q != 32'hFFFF_FFFF)
      perf_fetch_d = perf_fetch_q + 32'd1;
    if (stall_ev && perf_stall_q != 32'hFFFF_FFFF)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
